// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage, decoder and immediate generator:
// fetch FSM encoding, PC defaults and RV32I major opcodes.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP      = 32'd4;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single outstanding req/ack read, and a one-entry output
// register feeding decode. Redirects during an outstanding read are deferred.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] PC_STEP      = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  pend_r;
  logic [31:0]  instr_r;
  logic [31:0]  pc_out_r;
  logic         req_r;
  logic         valid_r;
  logic [31:0]  target_s;

  assign target_s = align_pc(redirect_pc_i);

  // Fetch FSM with PC, pending redirect target and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_VECTOR;
      pend_r   <= 32'h0000_0000;
      instr_r  <= 32'h0000_0000;
      pc_out_r <= RESET_VECTOR;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b1;
        end
        ST_FETCH: begin
          if (mem_ack_i && redirect_i) begin
            pc_r <= target_s;
          end else if (mem_ack_i) begin
            instr_r  <= mem_rdata_i;
            pc_out_r <= pc_r;
            state_r  <= ST_VALID;
            req_r    <= 1'b0;
            valid_r  <= 1'b1;
          end else if (redirect_i) begin
            // The request stays on the bus; its data is dropped in FLUSH.
            pend_r  <= target_s;
            state_r <= ST_FLUSH;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_FLUSH: begin
          if (mem_ack_i) begin
            pc_r    <= redirect_i ? target_s : pend_r;
            state_r <= ST_FETCH;
          end else if (redirect_i) begin
            pend_r <= target_s;
          end else begin
            state_r <= ST_FLUSH;
          end
        end
        ST_VALID: begin
          if (redirect_i) begin
            pc_r    <= target_s;
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end else if (!stall_i) begin
            pc_r    <= pc_r + PC_STEP;
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_VALID;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o     = req_r;
  assign mem_addr_o    = pc_r;
  assign instr_o       = instr_r;
  assign pc_o          = pc_out_r;
  assign instr_valid_o = valid_r;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate generator and decoder. Keeps the program counter and issues one word read at a time to instruction memory with a req/ack handshake.
- Holds the returned instruction in a single-entry output register and presents it with its PC to decode, which provides the instr_i input of the immediate generator.
- Accepts stall and branch/jump redirect from the execute stage.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, PC increment per consumed instruction.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_req_o  output  1  read request to instruction memory.
- mem_addr_o  output  32  word-aligned read address; stable while mem_req_o=1.
- mem_ack_i  input  1  read complete; mem_rdata_i valid in the same cycle.
- mem_rdata_i  input  32  instruction word.
- stall_i  input  1  downstream cannot accept the current instruction.
- redirect_i  input  1  taken branch/JAL/JALR; squash and refetch.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored and forced to 0.
- instr_o  output  32  fetched instruction, to decode and immediate generator.
- pc_o  output  32  PC of instr_o.
- instr_valid_o  output  1  instr_o/pc_o are valid.

Behaviour:
- FSM states: IDLE, FETCH, FLUSH, VALID. mem_req_o=1 only in FETCH or FLUSH. instr_valid_o=1 only in VALID.
- Reset (rst=1 at an edge):
  - state=IDLE, pc_q=RESET_VECTOR, pend_q=0, instr_o=32'h0, pc_o=RESET_VECTOR.
  - All outputs deasserted. Reset overrides every other input in the same cycle, including mid-request; a late ack arriving after reset is ignored in IDLE.
- IDLE: always moves to FETCH on the next edge. First mem_req_o is therefore one cycle after rst falls.
- FETCH: mem_addr_o=pc_q.
  - ack & !redirect: instr_o<=mem_rdata_i, pc_o<=pc_q, go to VALID.
  - ack & redirect: data dropped, pc_q<={redirect_pc_i[31:2],2'b00}, stay in FETCH.
  - !ack & redirect: pend_q<=aligned target, go to FLUSH. The address is held; the outstanding request is never retracted.
  - neither: stay, address held.
- FLUSH: mem_addr_o=pc_q (old address) until ack.
  - A further redirect overwrites pend_q (last target wins).
  - On ack: data dropped, pc_q<=pend_q, or the redirect target if redirect_i is set in that same cycle; go to FETCH.
- VALID: no request.
  - redirect (has priority over stall): instruction squashed, pc_q<=target, go to FETCH. instr_valid_o is 0 the next cycle.
  - !redirect & !stall: instruction consumed this cycle, pc_q<=pc_q+PC_STEP, go to FETCH.
  - stall: hold instr_o/pc_o/pc_q unchanged.
- Latency: ack in cycle N gives instr_valid_o=1 in N+1. Peak throughput is one instruction per 2 cycles.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0.
- An ack outside FETCH/FLUSH is a protocol error and is ignored.
- A redirect in IDLE is ignored.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit).
  - RESET_VECTOR default.
  - PC_STEP.
  - RV32I opcode localparams (LOAD, STORE, JAL, JALR, LUI, AUIPC, BRANCH, OP-IMM), so fetch, decode and the immediate generator use one definition.
- No sub-module needed: single module with FSM, pc_q, pend_q and output registers.

Test Plan:
- Reset release, memory acks in the same cycle as req, no stall:
  - mem_addr_o sequence is 0x0, 0x4, 0x8.
  - Each instr_valid_o pulse carries pc_o 0x0, 0x4, 0x8 and the matching rdata.
- ack delayed 3 cycles, redirect to 0x100 in the first wait cycle:
  - mem_addr_o stays 0x8 until ack; that data never appears on instr_o.
  - Next request address is 0x100; valid pc_o is 0x100.
- In VALID with stall_i=1 for 4 cycles:
  - instr_o/pc_o are unchanged and mem_req_o=0.
  - On release, next mem_addr_o = pc_o+4.
- redirect_i and stall_i together in VALID, redirect_pc_i=0x203:
  - Instruction squashed; next mem_addr_o=0x200.
- Two redirects during FLUSH (0x40 then 0x80) before ack:
  - Fetch resumes at 0x80.
- pc_q=0xFFFF_FFFC consumed: next mem_addr_o=0x0.
- rst asserted while FETCH waits, with ack arriving in the cycle after reset:
  - Outputs are 0 and the ack is ignored.
  - Fetch restarts at RESET_VECTOR.
